mer_meas_ctrl: RTL and testbench

- Measurement sequencer for the MER lookup-table block.
- Accumulates per-symbol mapper power and error power over a window of 2^ACC_LOG2 symbols, then averages each sum.
- Presents the averages to the LUT block, holds them stable for the LUT pipeline latency, and captures the 7-bit MER result.
- Sits between the slicer/error-computation path and the status/readout registers; supports single-shot and continuous measurement.

---
 rtl/mer_meas_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mer_meas_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mer_meas_ctrl.sv
// rtl/mer_meas_ctrl.sv - MER measurement sequencer: window accumulate, average, LUT handshake, capture.
// Optional build macro MER_HOLD_LAST_EN: keep previous mer_out when the LUT reports out-of-range.
module mer_meas_ctrl #(
  parameter int ACC_LOG2    = 12,
  parameter int LUT_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sym_en,
  input  logic [17:0] sym_power,
  input  logic [17:0] err_power_in,
  input  logic        start,
  input  logic        continuous,
  input  logic [6:0]  approx_mer,
  output logic [17:0] mapper_power,
  output logic [17:0] error_power,
  output logic        lut_en,
  output logic [6:0]  mer_out,
  output logic        mer_valid,
  output logic        mer_oor,
  output logic        busy
);

  localparam int ACC_W  = 17 + ACC_LOG2;
  localparam int WAIT_W = $clog2(LUT_LATENCY + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LUT_LATENCY - 1);
  localparam logic [6:0] MER_OOR_CODE = 7'h7F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_LOAD,
    S_WAIT,
    S_CAPTURE
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_map_q, acc_map_d;
  logic [ACC_W-1:0]    acc_err_q, acc_err_d;
  logic [ACC_LOG2-1:0] sym_cnt_q, sym_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [17:0]         mapper_power_q, mapper_power_d;
  logic [17:0]         error_power_q, error_power_d;
  logic                lut_en_q, lut_en_d;
  logic [6:0]          mer_out_q, mer_out_d;
  logic                mer_valid_q, mer_valid_d;
  logic                mer_oor_q, mer_oor_d;
  logic                busy_q, busy_d;
  logic                lut_says_oor;

  assign lut_says_oor = (approx_mer == MER_OOR_CODE);

  always_comb begin
    state_d        = state_q;
    acc_map_d      = acc_map_q;
    acc_err_d      = acc_err_q;
    sym_cnt_d      = sym_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    mapper_power_d = mapper_power_q;
    error_power_d  = error_power_q;
    lut_en_d       = lut_en_q;
    mer_out_d      = mer_out_q;
    mer_valid_d    = 1'b0;
    mer_oor_d      = mer_oor_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ACCUM;
          acc_map_d = '0;
          acc_err_d = '0;
          sym_cnt_d = '0;
        end
      end

      S_ACCUM: begin
        if (sym_en) begin
          acc_map_d = acc_map_q + ACC_W'(sym_power);
          acc_err_d = acc_err_q + ACC_W'(err_power_in);
          sym_cnt_d = sym_cnt_q + 1'b1;
          // Counter wraps to zero on the last symbol of the window.
          if (sym_cnt_q == '1) begin
            state_d  = S_LOAD;
            lut_en_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        mapper_power_d = 18'(acc_map_q >> ACC_LOG2);
        error_power_d  = 18'(acc_err_q >> ACC_LOG2);
        lut_en_d       = 1'b1;
        wait_cnt_d     = '0;
        state_d        = S_WAIT;
      end

      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      S_CAPTURE: begin
`ifdef MER_HOLD_LAST_EN
        if (!lut_says_oor) begin
          mer_out_d = approx_mer;
        end
`else
        mer_out_d = approx_mer;
`endif
        mer_oor_d   = lut_says_oor;
        mer_valid_d = 1'b1;
        lut_en_d    = 1'b0;
        if (continuous) begin
          state_d   = S_ACCUM;
          acc_map_d = '0;
          acc_err_d = '0;
          sym_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      acc_map_q      <= '0;
      acc_err_q      <= '0;
      sym_cnt_q      <= '0;
      wait_cnt_q     <= '0;
      mapper_power_q <= '0;
      error_power_q  <= '0;
      lut_en_q       <= 1'b0;
      mer_out_q      <= '0;
      mer_valid_q    <= 1'b0;
      mer_oor_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_map_q      <= acc_map_d;
      acc_err_q      <= acc_err_d;
      sym_cnt_q      <= sym_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      mapper_power_q <= mapper_power_d;
      error_power_q  <= error_power_d;
      lut_en_q       <= lut_en_d;
      mer_out_q      <= mer_out_d;
      mer_valid_q    <= mer_valid_d;
      mer_oor_q      <= mer_oor_d;
      busy_q         <= busy_d;
    end
  end

  assign mapper_power = mapper_power_q;
  assign error_power  = error_power_q;
  assign lut_en       = lut_en_q;
  assign mer_out      = mer_out_q;
  assign mer_valid    = mer_valid_q;
  assign mer_oor      = mer_oor_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mer_meas_ctrl.sv
// tb/tb_mer_meas_ctrl.sv - self-checking bench for mer_meas_ctrl with a stub LUT and window-level reference model.
module tb_mer_meas_ctrl;
  localparam int A   = 2;
  localparam int L   = 4;
  localparam int WIN = 1 << A;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sym_en = 1'b0;
  logic [17:0] sym_power = '0;
  logic [17:0] err_power_in = '0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [6:0]  approx_mer;
  logic [17:0] mapper_power;
  logic [17:0] error_power;
  logic        lut_en;
  logic [6:0]  mer_out;
  logic        mer_valid;
  logic        mer_oor;
  logic        busy;
  bit          force_oor = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Stub LUT: -1 when forced, 20 for the reference operating point, else a simple hash.
  function automatic logic [6:0] lut_f(input int m, input int e, input bit oor);
    if (oor) return 7'h7F;
    if (m == 2000 && e == 20) return 7'd20;
    return 7'((m + 3 * e) % 50);
  endfunction

  assign approx_mer = lut_f(int'(mapper_power), int'(error_power), force_oor);

  mer_meas_ctrl #(.ACC_LOG2(A), .LUT_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .sym_en(sym_en), .sym_power(sym_power),
    .err_power_in(err_power_in), .start(start), .continuous(continuous),
    .approx_mer(approx_mer), .mapper_power(mapper_power), .error_power(error_power),
    .lut_en(lut_en), .mer_out(mer_out), .mer_valid(mer_valid), .mer_oor(mer_oor),
    .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: symbols counted only while measuring and not in the
  // L+2 dead cycles after a window completes; result appears after those cycles.
  bit m_active = 0;
  int m_n = 0, m_sm = 0, m_se = 0, m_dead = 0, m_avg_m = 0, m_avg_e = 0;
  int e_map = 0, e_err = 0, e_mer = 0, e_oor = 0;
  bit m_valid = 0;
  logic [6:0] m_res;

  always begin
    @(posedge clk);
    m_valid = 0;
    if (reset) begin
      m_active = 0; m_n = 0; m_sm = 0; m_se = 0; m_dead = 0;
      e_map = 0; e_err = 0; e_mer = 0; e_oor = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_n = 0; m_sm = 0; m_se = 0;
      end
    end else if (m_dead > 0) begin
      m_dead--;
      if (m_dead == L + 1) begin
        e_map = m_avg_m; e_err = m_avg_e;
      end
      if (m_dead == 0) begin
        m_valid = 1;
        m_res = lut_f(m_avg_m, m_avg_e, force_oor);
        e_oor = (m_res == 7'h7F) ? 1 : 0;
`ifdef MER_HOLD_LAST_EN
        if (e_oor == 0) e_mer = int'(m_res);
`else
        e_mer = int'(m_res);
`endif
        m_active = continuous; m_n = 0; m_sm = 0; m_se = 0;
      end
    end else if (sym_en) begin
      m_sm += int'(sym_power);
      m_se += int'(err_power_in);
      m_n++;
      if (m_n == WIN) begin
        m_avg_m = m_sm / WIN;
        m_avg_e = m_se / WIN;
        m_dead = L + 2;
      end
    end
    #1;
    chk("model_busy", int'(busy), int'(m_active));
    chk("model_lut_en", int'(lut_en), (m_dead > 0) ? 1 : 0);
    chk("model_mapper_power", int'(mapper_power), e_map);
    chk("model_error_power", int'(error_power), e_err);
    chk("model_mer_valid", int'(mer_valid), int'(m_valid));
    chk("model_mer_out", int'(mer_out), e_mer);
    chk("model_mer_oor", int'(mer_oor), e_oor);
  end

  typedef struct packed {
    logic [3:0][17:0] sp;
    logic [3:0][17:0] ep;
    logic             oor;
    logic [17:0]      e_map;
    logic [17:0]      e_err;
    logic [6:0]       e_mer;
    logic [6:0]       e_mer_hold;
    logic             e_oor;
  } vec_t;

  function automatic vec_t mk(input int p0, p1, p2, p3, q0, q1, q2, q3, input bit oor,
                              input int em, ee, emer, ehold, input bit eoor);
    vec_t v;
    v.sp = {18'(p3), 18'(p2), 18'(p1), 18'(p0)};
    v.ep = {18'(q3), 18'(q2), 18'(q1), 18'(q0)};
    v.oor = oor; v.e_map = 18'(em); v.e_err = 18'(ee);
    v.e_mer = 7'(emer); v.e_mer_hold = 7'(ehold); v.e_oor = eoor;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[6];
  int lat, lut_cnt, pulses;
  bit got;

  initial begin
    tbl[0] = mk(2000, 2000, 2000, 2000, 20, 20, 20, 20, 0, 2000, 20, 20, 20, 0);
    tbl[1] = mk(1000, 1001, 1002, 1004, 1, 2, 2, 2, 0, 1001, 1, 4, 4, 0);
    tbl[2] = mk(500, 500, 500, 500, 7, 7, 7, 7, 1, 500, 7, 127, 4, 1);
    tbl[3] = mk(131071, 131071, 131071, 131071, 0, 0, 0, 0, 0, 131071, 0, 21, 21, 0);
    tbl[4] = mk(0, 1, 2, 0, 131071, 131071, 131071, 131070, 0, 0, 131070, 10, 10, 0);
    tbl[5] = mk(3, 3, 3, 3, 3, 3, 3, 3, 1, 3, 3, 127, 10, 1);

    reset = 1'b1;
    repeat (3) step();
    chk("reset_mapper_power", int'(mapper_power), 0);
    chk("reset_error_power", int'(error_power), 0);
    chk("reset_lut_en", int'(lut_en), 0);
    chk("reset_mer_out", int'(mer_out), 0);
    chk("reset_mer_valid", int'(mer_valid), 0);
    chk("reset_mer_oor", int'(mer_oor), 0);
    chk("reset_busy", int'(busy), 0);
    reset = 1'b0;
    sym_en = 1'b1;
    repeat (3) step();
    chk("idle_ignores_sym_en", int'(busy), 0);
    sym_en = 1'b0;

    for (int i = 0; i < 6; i++) begin
      force_oor = tbl[i].oor;
      start = 1'b1; sym_en = 1'b1;
      step();
      start = 1'b0;
      for (int s = 0; s < WIN; s++) begin
        sym_en = 1'b1; sym_power = tbl[i].sp[s]; err_power_in = tbl[i].ep[s];
        step();
      end
      sym_en = 1'b0;
      lat = 0; got = 0; lut_cnt = int'(lut_en);
      while (!got && lat < 30) begin
        step(); lat++;
        lut_cnt += int'(lut_en);
        if (mer_valid) got = 1;
      end
      chk("vec_latency", lat, L + 2);
      chk("vec_lut_en_cycles", lut_cnt, L + 2);
      chk("vec_mapper_power", int'(mapper_power), int'(tbl[i].e_map));
      chk("vec_error_power", int'(error_power), int'(tbl[i].e_err));
`ifdef MER_HOLD_LAST_EN
      chk("vec_mer_out", int'(mer_out), int'(tbl[i].e_mer_hold));
`else
      chk("vec_mer_out", int'(mer_out), int'(tbl[i].e_mer));
`endif
      chk("vec_mer_oor", int'(mer_oor), int'(tbl[i].e_oor));
      step();
      chk("vec_busy_done", int'(busy), 0);
      chk("vec_valid_pulse", int'(mer_valid), 0);
    end
    force_oor = 1'b0;

    // start while busy must not restart the window
    start = 1'b1; step(); start = 1'b0;
    sym_en = 1'b1; sym_power = 18'd100; err_power_in = 18'd4; step();
    sym_power = 18'd200; step();
    start = 1'b1; sym_power = 18'd300; step();
    start = 1'b0; sym_power = 18'd400; err_power_in = 18'd8; step();
    sym_en = 1'b0;
    lat = 0; got = 0;
    while (!got && lat < 30) begin
      step(); lat++;
      if (mer_valid) got = 1;
    end
    chk("busy_start_latency", lat, L + 2);
    chk("busy_start_mapper", int'(mapper_power), 250);
    chk("busy_start_error", int'(error_power), 5);

    // continuous mode: two full windows, drop continuous mid-third window
    continuous = 1'b1; start = 1'b1; step(); start = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 40; c++) begin
      sym_en = 1'b1;
      sym_power = 18'($urandom_range(131071, 0));
      err_power_in = 18'($urandom_range(131071, 0));
      if (c == 23) continuous = 1'b0;
      step();
      if (mer_valid) pulses++;
    end
    sym_en = 1'b0;
    chk("cont_pulses", pulses, 3);
    chk("cont_idle", int'(busy), 0);

    // reset in WAIT discards the window
    start = 1'b1; step(); start = 1'b0;
    sym_en = 1'b1; sym_power = 18'd999; err_power_in = 18'd9;
    repeat (WIN) step();
    sym_en = 1'b0;
    repeat (3) step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("midreset_mapper", int'(mapper_power), 0);
    chk("midreset_lut_en", int'(lut_en), 0);
    chk("midreset_mer_out", int'(mer_out), 0);
    chk("midreset_busy", int'(busy), 0);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      sym_en = 1'b1;
      step();
      if (mer_valid) pulses++;
    end
    sym_en = 1'b0;
    chk("midreset_no_valid", pulses, 0);

    // randomized continuous run against the model
    continuous = 1'b1; start = 1'b1; step();
    for (int c = 0; c < 400; c++) begin
      sym_en = ($urandom_range(3, 0) != 0);
      sym_power = 18'($urandom_range(131071, 0));
      err_power_in = 18'($urandom_range(131071, 0));
      start = (c < 300) && ($urandom_range(15, 0) == 0);
      if (c == 300) continuous = 1'b0;
      step();
    end
    sym_en = 1'b0; start = 1'b0;
    lat = 0;
    while (busy && lat < 40) begin
      step(); lat++;
    end
    chk("random_final_idle", int'(busy), 0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
